// File: rtl/common_pkg.sv
// Shared types and widths for the CLIC controller and its arbiter.
`default_nettype none

package common_pkg;

  localparam int PrioWidth  = 3;
  localparam int NumSrcDflt = 3;
  localparam int Entries    = NumSrcDflt + 1;
  localparam int IndexWidth = $clog2(Entries);

  typedef logic [IndexWidth-1:0] Index;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/can_clic.sv
// Combinational arbiter: picks the highest entry value, lowest index on ties.
`default_nettype none

module can_clic #(
  parameter int NumEntries = 4,
  parameter int PrioWidth  = 3,
  parameter int IdxWidth   = 2
) (
  input  logic [NumEntries*PrioWidth-1:0] entries_i,
  output logic [IdxWidth-1:0]             win_idx_o,
  output logic [PrioWidth-1:0]            win_prio_o
);

  always_comb begin
    win_idx_o  = '0;
    win_prio_o = entries_i[PrioWidth-1:0];
    for (int i = 1; i < NumEntries; i++) begin
      if (entries_i[i*PrioWidth +: PrioWidth] > win_prio_o) begin
        win_prio_o = entries_i[i*PrioWidth +: PrioWidth];
        win_idx_o  = IdxWidth'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clic_ctrl.sv
// Edge-triggered interrupt controller with priority threshold and nesting stack.
`default_nettype none

module clic_ctrl #(
  parameter int  NumSources = 3,
  parameter int  PrioWidth  = common_pkg::PrioWidth,
  parameter int  StackDepth = 4,
  localparam int DepthW     = $clog2(StackDepth + 1),
  localparam int IdxW       = common_pkg::IndexWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumSources-1:0] irq_i,
  input  logic                  cfg_we,
  input  logic [IdxW-1:0]       cfg_idx,
  input  logic [PrioWidth-1:0]  cfg_prio,
  input  logic                  cfg_en,
  output logic                  irq_valid,
  output logic [IdxW-1:0]       irq_id,
  input  logic                  irq_ready,
  input  logic                  mret_i,
  output logic [PrioWidth-1:0]  cur_thresh,
  output logic [DepthW-1:0]     depth_o,
  output logic                  err_o
);

  localparam int SpW        = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam int NumEntries = NumSources + 1;

  common_pkg::state_e state_q;

  logic                  valid_q;
  logic [IdxW-1:0]       id_q;
  logic [PrioWidth-1:0]  offer_prio_q;
  logic [PrioWidth-1:0]  thresh_q;
  logic [DepthW-1:0]     depth_q;
  logic                  err_q;
  logic [NumSources-1:0] irq_prev_q;
  logic [NumSources-1:0] pending_q;
  logic [NumSources-1:0] pending_d;
  logic [NumSources-1:0] en_q;
  logic [NumSources-1:0] clr_mask;
  logic [PrioWidth-1:0]  prio_q  [NumSources];
  logic [PrioWidth-1:0]  stack_q [StackDepth];

  logic [NumEntries*PrioWidth-1:0] entries;
  logic [IdxW-1:0]                 win_idx;
  logic [PrioWidth-1:0]            win_prio;
  logic                            take;
  logic                            candidate;
  logic                            has_room;
  logic [SpW-1:0]                  top_ptr;
  logic [SpW-1:0]                  push_ptr;

  assign take      = valid_q & irq_ready;
  assign candidate = win_prio > thresh_q;
  assign has_room  = depth_q < DepthW'(StackDepth);
  assign top_ptr   = SpW'(depth_q - DepthW'(1));
  assign push_ptr  = SpW'(depth_q);

  generate
    for (genvar i = 0; i < NumSources; i++) begin : g_src
      assign entries[i*PrioWidth +: PrioWidth] = (pending_q[i] & en_q[i]) ? prio_q[i] : '0;
      assign clr_mask[i] = take && (id_q == IdxW'(i));
    end
  endgenerate

  // The threshold competes as the last entry so a winner below it never wins strictly.
  assign entries[NumSources*PrioWidth +: PrioWidth] = thresh_q;

  // A new rising edge on the same cycle as the take keeps the source pending.
  assign pending_d = (pending_q & ~clr_mask) | (irq_i & ~irq_prev_q);

  can_clic #(
    .NumEntries (NumEntries),
    .PrioWidth  (PrioWidth),
    .IdxWidth   (IdxW)
  ) u_can_clic (
    .entries_i  (entries),
    .win_idx_o  (win_idx),
    .win_prio_o (win_prio)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= common_pkg::IDLE;
      valid_q      <= 1'b0;
      id_q         <= '0;
      offer_prio_q <= '0;
      thresh_q     <= '0;
      depth_q      <= '0;
      err_q        <= 1'b0;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      en_q         <= '0;
      for (int i = 0; i < NumSources; i++) prio_q[i] <= '0;
      for (int i = 0; i < StackDepth; i++) stack_q[i] <= '0;
    end else begin
      irq_prev_q <= irq_i;
      pending_q  <= pending_d;

      for (int i = 0; i < NumSources; i++) begin
        if (cfg_we && (cfg_idx == IdxW'(i))) begin
          prio_q[i] <= cfg_prio;
          en_q[i]   <= cfg_en;
        end
      end

      case (state_q)
        common_pkg::IDLE: begin
          if (candidate && has_room) begin
            state_q      <= common_pkg::OFFER;
            valid_q      <= 1'b1;
            id_q         <= win_idx;
            offer_prio_q <= win_prio;
          end
        end
        common_pkg::OFFER: begin
          if (irq_ready) begin
            state_q <= common_pkg::IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= common_pkg::IDLE;
          valid_q <= 1'b0;
        end
      endcase

      // Take and return together overwrite the top slot instead of pop-then-push.
      if (take && mret_i) begin
        if (depth_q != '0) stack_q[top_ptr] <= thresh_q;
        else               err_q            <= 1'b1;
        thresh_q <= offer_prio_q;
      end else if (take) begin
        stack_q[push_ptr] <= thresh_q;
        depth_q           <= depth_q + DepthW'(1);
        thresh_q          <= offer_prio_q;
      end else if (mret_i) begin
        if (depth_q == '0) begin
          err_q <= 1'b1;
        end else begin
          thresh_q <= stack_q[top_ptr];
          depth_q  <= depth_q - DepthW'(1);
        end
      end
    end
  end

  assign irq_valid  = valid_q;
  assign irq_id     = id_q;
  assign cur_thresh = thresh_q;
  assign depth_o    = depth_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_clic_ctrl.sv
// Directed scenarios plus random traffic checked against a queue-based reference model.
`default_nettype none

module tb_clic_ctrl;

  localparam int NS = 3;
  localparam int PW = 3;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] irq;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [PW-1:0] cfg_prio;
  logic          cfg_en;
  logic          irq_valid;
  logic [1:0]    irq_id;
  logic          irq_ready;
  logic          mret;
  logic [PW-1:0] cur_thresh;
  logic [2:0]    depth_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  clic_ctrl #(.NumSources(NS), .PrioWidth(PW), .StackDepth(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_i      (irq),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_prio   (cfg_prio),
    .cfg_en     (cfg_en),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .mret_i     (mret),
    .cur_thresh (cur_thresh),
    .depth_o    (depth_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_prio [NS];
  bit m_en   [NS];
  bit m_pend [NS];
  bit m_prev [NS];
  bit m_valid;
  int m_id;
  int m_oprio;
  int m_thr;
  bit m_err;
  int m_stk [$];

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
    end
    m_valid = 0; m_id = 0; m_oprio = 0; m_thr = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_edge();
    bit take;
    int best;
    int bestp;
    int old_id;
    int old_op;
    if (!rst_n) begin
      model_reset();
      return;
    end
    take   = m_valid && irq_ready;
    old_id = m_id;
    old_op = m_oprio;
    best   = -1;
    bestp  = m_thr;
    for (int i = 0; i < NS; i++)
      if (m_pend[i] && m_en[i] && m_prio[i] > bestp) begin
        best  = i;
        bestp = m_prio[i];
      end
    if (m_valid) begin
      if (take) m_valid = 0;
    end else if (best >= 0 && m_stk.size() < SD) begin
      m_valid = 1; m_id = best; m_oprio = bestp;
    end
    if (take && mret) begin
      if (m_stk.size() > 0) m_stk[m_stk.size()-1] = m_thr;
      else m_err = 1;
      m_thr = old_op;
    end else if (take) begin
      m_stk.push_back(m_thr);
      m_thr = old_op;
    end else if (mret) begin
      if (m_stk.size() == 0) m_err = 1;
      else m_thr = m_stk.pop_back();
    end
    for (int i = 0; i < NS; i++) begin
      if (take && i == old_id) m_pend[i] = 0;
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
    end
    if (cfg_we && int'(cfg_idx) < NS) begin
      m_prio[cfg_idx] = int'(cfg_prio);
      m_en[cfg_idx]   = cfg_en;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("valid",  {31'd0, irq_valid},  {31'd0, m_valid});
    chk("id",     {30'd0, irq_id},     m_id);
    chk("thresh", {29'd0, cur_thresh}, m_thr);
    chk("depth",  {29'd0, depth_o},    m_stk.size());
    chk("err",    {31'd0, err_o},      {31'd0, m_err});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_cfg(input int idx, input int prio, input bit en);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_prio = PW'(prio); cfg_en = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input int idx);
    irq[idx] = 1'b1;
    cycle();
    irq[idx] = 1'b0;
  endtask

  task automatic mret_pulse();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
  endtask

  task automatic take_src(input int idx, input int prio);
    irq_ready = 1'b1;
    set_cfg(idx, prio, 1'b1);
    pulse(idx);
    run(2);
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_prio = '0; cfg_en = 1'b0;
    irq_ready = 1'b0; mret = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, irq_valid}, 0);
    chk("rst_depth", {29'd0, depth_o}, 0);
    run(2);
    #2 rst_n = 1'b1;

    // Scenario 1: two-edge latency, then nesting one level
    irq_ready = 1'b1;
    set_cfg(0, 2, 1'b1);
    pulse(0);
    chk("s1_pre", {31'd0, irq_valid}, 0);
    cycle();
    chk("s1_valid", {31'd0, irq_valid}, 1);
    chk("s1_id", {30'd0, irq_id}, 0);
    cycle();
    chk("s1_thr", {29'd0, cur_thresh}, 2);
    chk("s1_depth", {29'd0, depth_o}, 1);
    mret_pulse();

    // Scenario 2: equal priority does not beat threshold
    take_src(1, 3);
    chk("s2_thr", {29'd0, cur_thresh}, 3);
    set_cfg(2, 3, 1'b1);
    pulse(2);
    run(4);
    chk("s2_block", {31'd0, irq_valid}, 0);
    irq_ready = 1'b0;
    mret_pulse();
    chk("s2_thr0", {29'd0, cur_thresh}, 0);
    cycle();
    chk("s2_offer", {31'd0, irq_valid}, 1);
    chk("s2_id", {30'd0, irq_id}, 2);
    irq_ready = 1'b1;
    cycle();
    mret_pulse();

    // Scenario 3: offer stays stable while a higher source arrives
    irq_ready = 1'b0;
    set_cfg(0, 2, 1'b1);
    pulse(0);
    cycle();
    set_cfg(2, 5, 1'b1);
    pulse(2);
    run(3);
    chk("s3_hold_v", {31'd0, irq_valid}, 1);
    chk("s3_hold_id", {30'd0, irq_id}, 0);
    irq_ready = 1'b1;
    cycle();
    chk("s3_thr", {29'd0, cur_thresh}, 2);
    cycle();
    chk("s3_pre_id", {30'd0, irq_id}, 2);
    cycle();
    chk("s3_thr5", {29'd0, cur_thresh}, 5);
    mret_pulse();
    mret_pulse();

    // Scenario 4: full stack blocks new offers
    take_src(0, 1);
    take_src(1, 2);
    take_src(2, 3);
    take_src(0, 4);
    chk("s4_full", {29'd0, depth_o}, 4);
    set_cfg(1, 6, 1'b1);
    pulse(1);
    run(3);
    chk("s4_block", {31'd0, irq_valid}, 0);
    mret_pulse();
    chk("s4_thr3", {29'd0, cur_thresh}, 3);
    cycle();
    chk("s4_resume", {31'd0, irq_valid}, 1);
    chk("s4_id", {30'd0, irq_id}, 1);
    cycle();
    for (int k = 0; k < 4; k++) mret_pulse();

    // Scenario 5: underflow is sticky, take+mret replaces top
    mret_pulse();
    chk("s5_err", {31'd0, err_o}, 1);
    chk("s5_thr", {29'd0, cur_thresh}, 0);
    take_src(0, 4);
    irq_ready = 1'b0;
    set_cfg(1, 6, 1'b1);
    pulse(1);
    cycle();
    chk("s5_offer", {31'd0, irq_valid}, 1);
    irq_ready = 1'b1;
    mret_pulse();
    chk("s5_depth", {29'd0, depth_o}, 1);
    chk("s5_thr6", {29'd0, cur_thresh}, 6);
    chk("s5_sticky", {31'd0, err_o}, 1);

    // Scenario 6: asynchronous reset during an offer
    irq_ready = 1'b0;
    set_cfg(2, 7, 1'b1);
    pulse(2);
    cycle();
    chk("s6_offer", {31'd0, irq_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'd0, irq_valid}, 0);
    chk("s6_id", {30'd0, irq_id}, 0);
    chk("s6_thr", {29'd0, cur_thresh}, 0);
    chk("s6_depth", {29'd0, depth_o}, 0);
    chk("s6_err", {31'd0, err_o}, 0);
    model_reset();
    cycle();
    #2 rst_n = 1'b1;

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_idx   = 2'($urandom_range(0, 3));
      cfg_prio  = PW'($urandom);
      cfg_en    = ($urandom_range(0, 3) != 0);
      irq       = NS'($urandom);
      irq_ready = ($urandom_range(0, 2) != 0);
      mret      = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
